// File: rtl/sram_stream_engine_if.sv
// ---------------------------------------------------------------------------
// sram_stream_engine_if
// Bundles the control handshake, configuration and both SRAM ports of the
// streaming engine.
//   Control    : dut_run (start), dut_busy, dut_done, dut_word_count
//   Config     : cfg_src_base, cfg_dst_base, cfg_len, cfg_mode
//   Input SRAM : dut_sram_read_addr (out), dut_sram_read_data (in, 1-cycle latency)
//   Output SRAM: dut_sram_write_enable, dut_sram_write_addr, dut_sram_write_data
// Modports:
//   slave  - the engine's view (consumes config/read data, drives the rest)
//   master - the environment's view (controller plus both SRAMs)
// ---------------------------------------------------------------------------
interface sram_stream_engine_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
);
    logic              dut_run;
    logic [ADDR_W-1:0] cfg_src_base;
    logic [ADDR_W-1:0] cfg_dst_base;
    logic [ADDR_W-1:0] cfg_len;
    logic [1:0]        cfg_mode;
    logic              dut_busy;
    logic              dut_done;
    logic [ADDR_W-1:0] dut_sram_read_addr;
    logic [DATA_W-1:0] dut_sram_read_data;
    logic              dut_sram_write_enable;
    logic [ADDR_W-1:0] dut_sram_write_addr;
    logic [DATA_W-1:0] dut_sram_write_data;
    logic [ADDR_W-1:0] dut_word_count;

    modport slave (
        input  dut_run, cfg_src_base, cfg_dst_base, cfg_len, cfg_mode,
        input  dut_sram_read_data,
        output dut_busy, dut_done, dut_word_count,
        output dut_sram_read_addr,
        output dut_sram_write_enable, dut_sram_write_addr, dut_sram_write_data
    );

    modport master (
        output dut_run, cfg_src_base, cfg_dst_base, cfg_len, cfg_mode,
        output dut_sram_read_data,
        input  dut_busy, dut_done, dut_word_count,
        input  dut_sram_read_addr,
        input  dut_sram_write_enable, dut_sram_write_addr, dut_sram_write_data
    );
endinterface

// File: rtl/sram_stream_engine.sv
// ---------------------------------------------------------------------------
// sram_stream_engine
// Streams cfg_len words from the input SRAM to the output SRAM, transforming
// each word (copy / invert / running sum / running unsigned max) on the way.
// Three-stage pipeline, one word per cycle: issue read, capture + transform,
// registered write.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high reset
//   bus   - sram_stream_engine_if.slave (handshake, config, both SRAM ports)
// ---------------------------------------------------------------------------
module sram_stream_engine #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    sram_stream_engine_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        MODE_COPY   = 2'd0,
        MODE_INVERT = 2'd1,
        MODE_SUM    = 2'd2,
        MODE_MAX    = 2'd3
    } mode_t;

    state_t            state_q, state_d;
    mode_t             mode_q, mode_d;
    logic [ADDR_W-1:0] dst_base_q, dst_base_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] issue_cnt_q, issue_cnt_d;
    logic              rd_pend_q, rd_pend_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [ADDR_W-1:0] read_addr_q, read_addr_d;
    logic              write_enable_q, write_enable_d;
    logic [ADDR_W-1:0] write_addr_q, write_addr_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic [ADDR_W-1:0] word_count_q, word_count_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] xform;

    // Next-state logic. The FSM owns the issue stage; the capture stage runs
    // whenever a read was issued in the previous cycle. DRAIN covers the
    // capture of the last word and DONE covers its write, so the done pulse
    // lands right after the final write and the FSM is already back in IDLE
    // on that edge, ready to accept a back-to-back start.
    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        dst_base_d     = dst_base_q;
        len_d          = len_q;
        issue_cnt_d    = issue_cnt_q;
        rd_pend_d      = 1'b0;
        acc_d          = acc_q;
        read_addr_d    = read_addr_q;
        write_enable_d = 1'b0;
        write_addr_d   = write_addr_q;
        write_data_d   = write_data_q;
        word_count_d   = word_count_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        xform          = bus.dut_sram_read_data;

        case (state_q)
            IDLE: begin
                if (bus.dut_run) begin
                    mode_d       = mode_t'(bus.cfg_mode);
                    dst_base_d   = bus.cfg_dst_base;
                    len_d        = bus.cfg_len;
                    read_addr_d  = bus.cfg_src_base;
                    issue_cnt_d  = '0;
                    word_count_d = '0;
                    acc_d        = '0;
                    busy_d       = 1'b1;
                    state_d      = (bus.cfg_len == '0) ? DONE : READ;
                end
            end
            READ: begin
                rd_pend_d = 1'b1;
                if (issue_cnt_q == len_q - ADDR_W'(1)) begin
                    state_d = DRAIN;
                end else begin
                    issue_cnt_d = issue_cnt_q + ADDR_W'(1);
                    read_addr_d = read_addr_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The write index equals the number of words already written, so the
        // word counter doubles as the destination offset.
        if (rd_pend_q) begin
            case (mode_q)
                MODE_COPY:   xform = bus.dut_sram_read_data;
                MODE_INVERT: xform = ~bus.dut_sram_read_data;
                MODE_SUM:    xform = acc_q + bus.dut_sram_read_data;
                MODE_MAX:    xform = (bus.dut_sram_read_data > acc_q) ?
                                     bus.dut_sram_read_data : acc_q;
                default:     xform = bus.dut_sram_read_data;
            endcase
            if (mode_q == MODE_SUM || mode_q == MODE_MAX) begin
                acc_d = xform;
            end
            write_enable_d = 1'b1;
            write_addr_d   = dst_base_q + word_count_q;
            write_data_d   = xform;
            word_count_d   = word_count_q + ADDR_W'(1);
        end
    end

    // State and output registers; reset clears everything at once, which also
    // aborts any transfer in flight without a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            mode_q         <= MODE_COPY;
            dst_base_q     <= '0;
            len_q          <= '0;
            issue_cnt_q    <= '0;
            rd_pend_q      <= 1'b0;
            acc_q          <= '0;
            read_addr_q    <= '0;
            write_enable_q <= 1'b0;
            write_addr_q   <= '0;
            write_data_q   <= '0;
            word_count_q   <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            dst_base_q     <= dst_base_d;
            len_q          <= len_d;
            issue_cnt_q    <= issue_cnt_d;
            rd_pend_q      <= rd_pend_d;
            acc_q          <= acc_d;
            read_addr_q    <= read_addr_d;
            write_enable_q <= write_enable_d;
            write_addr_q   <= write_addr_d;
            write_data_q   <= write_data_d;
            word_count_q   <= word_count_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign bus.dut_busy              = busy_q;
    assign bus.dut_done              = done_q;
    assign bus.dut_sram_read_addr    = read_addr_q;
    assign bus.dut_sram_write_enable = write_enable_q;
    assign bus.dut_sram_write_addr   = write_addr_q;
    assign bus.dut_sram_write_data   = write_data_q;
    assign bus.dut_word_count        = word_count_q;

endmodule
